ch_arb: RTL and testbench
=========================

CH_ARB -- requirements
Module: ch_arb

Interface
REQ-001 Parameter: TO_CYC, default 4096; RUN-state watchdog limit in cycles without an engine put strobe; 0 disables the watchdog.
REQ-002 wb_clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-003 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-004 req0, req1  in  1  channel 0/1 has a job pending; level-sensitive.
REQ-005 len0, len1  in  16  job length in 64-bit words, sampled at grant; 0 means an empty job.
REQ-006 m_src_empty0/1, m_dst_full0/1  in  1  per-channel FIFO status from each ch instance.
REQ-007 eng_getn, eng_putn, eng_endn  in  1  active-low strobes from the shared mover engine.
REQ-008 m_reset0/1  out  1  one-cycle channel FIFO reset pulse to the ch instance.
REQ-009 m_src_getn0/1, m_dst_putn0/1, m_endn0/1  out  1  active-low strobes routed to the ch instances.
REQ-010 gnt0, gnt1  out  1  channel owns the engine; one-hot or zero.
REQ-011 eng_src_empty, eng_dst_full  out  1  granted channel's FIFO status to the engine.
REQ-012 eng_start  out  1  one-cycle pulse at the start of RUN.
REQ-013 busy  out  1  state is not IDLE.
REQ-014 xfer_cnt  out  16  words put in the current or most recent job.
REQ-015 err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-016 FSM states: IDLE, RST, RUN, DONE; all transitions registered.
REQ-017 IDLE: when any req is high, select the channel, latch its len, clear xfer_cnt, and go to RST.
REQ-018 Selection is round-robin: with both reqs high, the channel not served last wins; after reset, ch0 has priority.
REQ-019 RST lasts exactly one cycle: m_resetX=1 for the selected channel only; go to RUN, or to DONE when the latched len is 0.
REQ-020 RUN entry: gntX=1 and eng_start=1 for exactly the first RUN cycle.
REQ-021 RUN pass-through is combinational and zero-latency: m_src_getnX=eng_getn and m_dst_putnX=eng_putn for the granted channel; the ungranted channel's strobes are held at 1.
REQ-022 eng_src_empty/eng_dst_full mux the granted channel's status; when no channel is granted, both are 1 (engine stalled).
REQ-023 Each RUN cycle with eng_putn=0 increments xfer_cnt by 1; the count saturates at 16'hFFFF and never wraps.
REQ-024 RUN exits to DONE in the cycle after the put that makes xfer_cnt equal len, or after eng_endn=0, whichever comes first; when both occur in the same cycle, the exit happens once.
REQ-025 Watchdog: in RUN, TO_CYC consecutive cycles without eng_putn=0 cause err=1 for one cycle and a transition to DONE.
REQ-026 DONE lasts exactly one cycle: m_endnX=0 and gntX=0; record X as last served; return to IDLE.
REQ-027 Deasserting reqX during RST or RUN is ignored; the job runs to completion.
REQ-028 An eng_putn/eng_getn strobe outside RUN is discarded: no count change and no routing.
REQ-029 Minimum turnaround: from req high in IDLE, gnt rises 2 cycles later; back-to-back jobs are separated by DONE and IDLE, one cycle each.

Reset
REQ-030 wb_rst_i=1 forces, on the next edge: IDLE, gnt0/1=0, m_reset0/1=0, all active-low strobes=1, eng_start=0, busy=0, err=0, xfer_cnt=0, watchdog=0, last-served=ch1 (so ch0 has priority).
REQ-031 A reset during RUN aborts the job without asserting m_endnX or err.

Structure
REQ-032 The shared package holds the FSM state encoding, the length width (16), and the TO_CYC default.
REQ-033 One sub-module, ch_arb_rr: a 2-way round-robin picker with last-served state; the FSM, counter, and muxes live in ch_arb.

Verification
REQ-034 req0=1, len0=4, four eng_putn pulses -> m_reset0 pulse, gnt0 for the RUN span, xfer_cnt=4, m_endn0 low one cycle, gnt1 never high.
REQ-035 req0=req1=1 held after reset, len=2 each -> grants alternate ch0, ch1, ch0; each gnt rises 2 cycles after the job's IDLE cycle.
REQ-036 req1=1, len1=0 -> m_reset1 pulse, then DONE with m_endn1 low, no gnt1, no eng_start, xfer_cnt=0.
REQ-037 len0=8, eng_endn=0 after 3 puts -> DONE with xfer_cnt=3; ch1 gets the next grant if requesting.
REQ-038 TO_CYC=16, RUN with no puts -> err pulse on cycle 16, then DONE, gnt0 drops.
REQ-039 wb_rst_i=1 mid-RUN after 2 puts -> all outputs at reset values next cycle, no m_endn0, no err.

Source files
------------

// File: rtl/ch_arb_pkg.sv
// ch_arb_pkg: shared definitions for the two-channel engine arbiter.
//   LEN_W      - job length / transfer count width
//   TO_CYC_DEF - default RUN-state watchdog limit (0 disables)
//   state_t    - arbiter FSM state encoding (ST_IDLE, ST_RST, ST_RUN, ST_DONE)
//   sat_inc    - saturating increment for the transfer counter
package ch_arb_pkg;

  localparam int unsigned LEN_W      = 16;
  localparam int unsigned TO_CYC_DEF = 4096;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RST  = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/ch_arb_rr.sv
// ch_arb_rr: 2-way round-robin picker with last-served state.
//   clk_i, rst_i     - clock, synchronous active-high reset
//   req0_i, req1_i   - channel requests
//   upd_i, upd_ch_i  - record upd_ch_i as the last-served channel
//   pick_o           - selected channel (0/1); meaningful only when a req is high
// After reset ch1 counts as last served, so ch0 wins the first tie.
module ch_arb_rr (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic upd_ch_i,
  output logic pick_o
);

  logic last_q;

  always_comb begin
    if (req0_i && req1_i) pick_o = ~last_q;
    else                  pick_o = ~req0_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)      last_q <= 1'b1;
    else if (upd_i) last_q <= upd_ch_i;
  end

endmodule

// File: rtl/ch_arb.sv
// ch_arb: arbitrates a shared mover engine between two channel instances.
//   wb_clk_i, wb_rst_i            - clock, synchronous active-high reset
//   req0/1, len0/1                - job request level and length in words
//   m_src_empty0/1, m_dst_full0/1 - per-channel FIFO status
//   eng_getn/putn/endn            - active-low engine strobes
//   m_reset0/1                    - one-cycle channel FIFO reset
//   m_src_getn0/1, m_dst_putn0/1,
//   m_endn0/1                     - active-low strobes to the channels
//   gnt0/1                        - engine ownership (RUN only)
//   eng_src_empty, eng_dst_full   - granted channel status (1 when idle)
//   eng_start                     - first RUN cycle pulse
//   busy, xfer_cnt, err           - status, words put, watchdog pulse
// Sequence per job: IDLE -> RST -> RUN -> DONE -> IDLE (RUN skipped for len 0).
module ch_arb
  import ch_arb_pkg::*;
#(
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             m_src_empty0,
  input  logic             m_src_empty1,
  input  logic             m_dst_full0,
  input  logic             m_dst_full1,
  input  logic             eng_getn,
  input  logic             eng_putn,
  input  logic             eng_endn,
  output logic             m_reset0,
  output logic             m_reset1,
  output logic             m_src_getn0,
  output logic             m_src_getn1,
  output logic             m_dst_putn0,
  output logic             m_dst_putn1,
  output logic             m_endn0,
  output logic             m_endn1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             eng_src_empty,
  output logic             eng_dst_full,
  output logic             eng_start,
  output logic             busy,
  output logic [LEN_W-1:0] xfer_cnt,
  output logic             err
);

  localparam logic [31:0] WD_LAST = TO_CYC - 1;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      wd_q, wd_d;
  logic             start_q, start_d;
  logic             pick;
  logic             put;
  logic             wd_hit;
  logic [LEN_W-1:0] cnt_inc;

  ch_arb_rr u_rr (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .req0_i   (req0),
    .req1_i   (req1),
    .upd_i    (state_q == ST_DONE),
    .upd_ch_i (sel_q),
    .pick_o   (pick)
  );

  assign put     = ~eng_putn;
  assign cnt_inc = sat_inc(cnt_q);
  // wd_q counts prior put-less RUN cycles; this cycle is the TO_CYC-th one.
  assign wd_hit  = (TO_CYC != 0) && (state_q == ST_RUN) && !put && (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    start_d = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          sel_d   = pick;
          len_d   = pick ? len1 : len0;
          cnt_d   = '0;
          state_d = ST_RST;
        end
      end
      ST_RST: begin
        wd_d = '0;
        if (len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end
      end
      ST_RUN: begin
        err = wd_hit;
        if (put) begin
          cnt_d = cnt_inc;
          wd_d  = '0;
        end else begin
          wd_d  = wd_q + 32'd1;
        end
        if ((put && (cnt_inc == len_q)) || !eng_endn || wd_hit)
          state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    gnt0          = (state_q == ST_RUN) && !sel_q;
    gnt1          = (state_q == ST_RUN) &&  sel_q;
    m_reset0      = (state_q == ST_RST) && !sel_q;
    m_reset1      = (state_q == ST_RST) &&  sel_q;
    m_endn0       = !((state_q == ST_DONE) && !sel_q);
    m_endn1       = !((state_q == ST_DONE) &&  sel_q);
    m_src_getn0   = !gnt0 || eng_getn;
    m_src_getn1   = !gnt1 || eng_getn;
    m_dst_putn0   = !gnt0 || eng_putn;
    m_dst_putn1   = !gnt1 || eng_putn;
    eng_src_empty = gnt0 ? m_src_empty0 : (gnt1 ? m_src_empty1 : 1'b1);
    eng_dst_full  = gnt0 ? m_dst_full0  : (gnt1 ? m_dst_full1  : 1'b1);
    eng_start     = start_q;
    busy          = (state_q != ST_IDLE);
    xfer_cnt      = cnt_q;
  end

endmodule

// File: tb/tb_ch_arb.sv
// tb_ch_arb: randomized self-checking bench for ch_arb against a job-level
// reference model (TO_CYC reduced to 16 so the watchdog fires in reach).
module tb_ch_arb;

  localparam int TO = 16;
  localparam int NCYC = 6000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] len0 = '0, len1 = '0;
  logic        m_src_empty0 = 1'b0, m_src_empty1 = 1'b0;
  logic        m_dst_full0 = 1'b0, m_dst_full1 = 1'b0;
  logic        eng_getn = 1'b1, eng_putn = 1'b1, eng_endn = 1'b1;
  logic        m_reset0, m_reset1, m_src_getn0, m_src_getn1;
  logic        m_dst_putn0, m_dst_putn1, m_endn0, m_endn1;
  logic        gnt0, gnt1, eng_src_empty, eng_dst_full, eng_start, busy, err;
  logic [15:0] xfer_cnt;

  always #5 wb_clk_i = ~wb_clk_i;

  ch_arb #(.TO_CYC(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .m_src_empty0(m_src_empty0), .m_src_empty1(m_src_empty1),
    .m_dst_full0(m_dst_full0), .m_dst_full1(m_dst_full1),
    .eng_getn(eng_getn), .eng_putn(eng_putn), .eng_endn(eng_endn),
    .m_reset0(m_reset0), .m_reset1(m_reset1),
    .m_src_getn0(m_src_getn0), .m_src_getn1(m_src_getn1),
    .m_dst_putn0(m_dst_putn0), .m_dst_putn1(m_dst_putn1),
    .m_endn0(m_endn0), .m_endn1(m_endn1),
    .gnt0(gnt0), .gnt1(gnt1),
    .eng_src_empty(eng_src_empty), .eng_dst_full(eng_dst_full),
    .eng_start(eng_start), .busy(busy), .xfer_cnt(xfer_cnt), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: job phases, owning channel, words put, quiet cycles.
  typedef enum {P_WAIT, P_CLR, P_XFER, P_FIN} ph_e;
  ph_e ph;
  int  ch, last, jlen, words, quiet;
  bit  first;
  int  n_wd, n_jobs;

  task automatic model_reset();
    ph = P_WAIT; ch = 0; last = 1; jlen = 0; words = 0; quiet = 0; first = 0;
  endtask

  task automatic model_check();
    bit xf, e_err;
    logic [1:0] g;
    xf = (ph == P_XFER);
    g  = {xf && ch == 1, xf && ch == 0};
    e_err = xf && eng_putn && (quiet + 1 == TO);
    check("gnt",       {gnt1, gnt0}, g);
    check("m_reset",   {m_reset1, m_reset0}, {ph == P_CLR && ch == 1, ph == P_CLR && ch == 0});
    check("m_endn",    {m_endn1, m_endn0}, {!(ph == P_FIN && ch == 1), !(ph == P_FIN && ch == 0)});
    check("start_err_busy", {eng_start, err, busy}, {xf && first, e_err, ph != P_WAIT});
    check("src_getn",  {m_src_getn1, m_src_getn0}, {!g[1] || eng_getn, !g[0] || eng_getn});
    check("dst_putn",  {m_dst_putn1, m_dst_putn0}, {!g[1] || eng_putn, !g[0] || eng_putn});
    check("eng_stat",  {eng_src_empty, eng_dst_full},
          g[0] ? {m_src_empty0, m_dst_full0} : g[1] ? {m_src_empty1, m_dst_full1} : 2'b11);
    check("xfer_cnt",  xfer_cnt, words);
    if (e_err) n_wd++;
  endtask

  task automatic model_step();
    bit put;
    if (wb_rst_i) begin
      model_reset();
      return;
    end
    case (ph)
      P_WAIT: if (req0 || req1) begin
        ch    = (req0 && req1) ? 1 - last : (req0 ? 0 : 1);
        jlen  = (ch == 0) ? int'(len0) : int'(len1);
        words = 0;
        ph    = P_CLR;
        n_jobs++;
      end
      P_CLR: begin
        quiet = 0;
        first = (jlen != 0);
        ph    = (jlen == 0) ? P_FIN : P_XFER;
      end
      P_XFER: begin
        first = 0;
        put = !eng_putn;
        if (put) begin
          if (words < 65535) words++;
          quiet = 0;
        end else begin
          quiet++;
        end
        if ((put && words == jlen) || !eng_endn || quiet == TO) ph = P_FIN;
      end
      P_FIN: begin
        last = ch;
        ph   = P_WAIT;
      end
    endcase
  endtask

  initial begin
    int mode;
    n_wd = 0; n_jobs = 0;
    mode = 0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge wb_clk_i);
      #1;
      if (cyc % 50 == 0) mode = $urandom_range(0, 2);
      wb_rst_i     = (cyc < 2) || ($urandom_range(0, 299) == 0);
      req0         = (cyc > 3) && ($urandom_range(0, 3) != 0);
      req1         = (cyc > 3) && ($urandom_range(0, 2) != 0);
      len0         = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      len1         = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      m_src_empty0 = 1'($urandom_range(0, 1));
      m_src_empty1 = 1'($urandom_range(0, 1));
      m_dst_full0  = 1'($urandom_range(0, 1));
      m_dst_full1  = 1'($urandom_range(0, 1));
      eng_getn     = 1'($urandom_range(0, 1));
      case (mode)
        0:       eng_putn = 1'($urandom_range(0, 1));
        1:       eng_putn = 1'b1;
        default: eng_putn = ($urandom_range(0, 7) != 0);
      endcase
      eng_endn = (mode == 0) ? ($urandom_range(0, 31) != 0) : 1'b1;
      #1;
      model_check();
      model_step();
    end
    check("jobs_seen", 32'(n_jobs > 20), 32'd1);
    check("watchdog_seen", 32'(n_wd > 0), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
